uart_tx_fifo: RTL and testbench

Byte-buffering front end for the UART transmit path. It accepts bytes from the system side through a single-cycle write strobe and stores them in a FIFO. It launches them one at a time into the transmitter through its Start/Data/EOT handshake, so software can queue a burst without polling the transmitter between bytes.

---
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO for the UART: queues bytes from single-cycle write
// strobes and feeds them to the transmitter one frame at a time via Start/Data/EOT.
module uart_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Wr_En,
  input  logic [7:0]    Wr_Data,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Level,
  output logic          Overflow,
  output logic          Busy,
  output logic          Tx_Start,
  output logic [7:0]    Tx_Data,
  input  logic          Tx_Eot
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic        overflow_q, overflow_d;
  logic        txStart_q, txStart_d;
  logic [7:0]  txData_q, txData_d;
  logic        wrAccept;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign Empty    = (wrPtr_q == rdPtr_q);
  assign Full     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign Level    = wrPtr_q - rdPtr_q;
  assign wrAccept = Wr_En && !Full;

  assign Overflow = overflow_q;
  assign Tx_Start = txStart_q;
  assign Tx_Data  = txData_q;
  assign Busy     = (state_q != IDLE) || !Empty;

  always_comb begin
    wrPtr_d    = wrAccept ? (wrPtr_q + 1'b1) : wrPtr_q;
    overflow_d = Wr_En && Full;
  end

  // Tx_Start only ever comes from a register, so the transmitter's
  // combinational EOT drop during Start cannot form a loop.
  always_comb begin
    state_d   = state_q;
    rdPtr_d   = rdPtr_q;
    txStart_d = 1'b0;
    txData_d  = txData_q;
    case (state_q)
      IDLE: begin
        if (!Empty && Tx_Eot) begin
          txData_d  = mem_q[rdPtr_q[AW-1:0]];
          rdPtr_d   = rdPtr_q + 1'b1;
          txStart_d = 1'b1;
          state_d   = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (Tx_Eot) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
      txStart_q  <= 1'b0;
      txData_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
      txStart_q  <= txStart_d;
      txData_q   <= txData_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n && wrAccept) begin
      mem_q[wrPtr_q[AW-1:0]] <= Wr_Data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized traffic, with a
// queue-based scoreboard and a simple transmitter model driving Tx_Eot.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          Clk     = 1'b0;
  logic          Rst_n   = 1'b0;
  logic          Wr_En   = 1'b0;
  logic [7:0]    Wr_Data = 8'h00;
  logic          Full;
  logic          Empty;
  logic [AW:0]   Level;
  logic          Overflow;
  logic          Busy;
  logic          Tx_Start;
  logic [7:0]    Tx_Data;
  logic          Tx_Eot;

  logic eotHold   = 1'b0;
  int   frameLen  = 80;
  int   txCount   = 0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  bit   monitorOn   = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Wr_En    (Wr_En),
    .Wr_Data  (Wr_Data),
    .Full     (Full),
    .Empty    (Empty),
    .Level    (Level),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Tx_Start (Tx_Start),
    .Tx_Data  (Tx_Data),
    .Tx_Eot   (Tx_Eot)
  );

  always #5 Clk = ~Clk;

  // Transmitter model: busy for frameLen clocks after each Start, unaffected by our reset.
  always @(posedge Clk) begin
    if (Tx_Start) txCount <= frameLen;
    else if (txCount > 0) txCount <= txCount - 1;
  end
  assign Tx_Eot = !eotHold && (txCount == 0) && !Tx_Start;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: expected bytes in order, occupancy as accepted minus launched.
  logic [7:0] expQ[$];
  int         modelLevel  = 0;
  bit         pendWrite   = 1'b0;
  bit         expOverflow = 1'b0;
  bit         resetPrev   = 1'b0;
  logic [7:0] pendByte    = 8'h00;
  logic [7:0] lastData    = 8'h00;

  initial begin
    forever begin
      @(negedge Clk);
      if (monitorOn) begin
        if (resetPrev) begin
          expQ.delete();
          modelLevel = 0;
          lastData   = 8'h00;
        end else if (pendWrite) begin
          expQ.push_back(pendByte);
          modelLevel++;
        end
        if (Tx_Start) begin
          testsRun++;
          if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL mon_launch: Tx_Start=1 data=%h with nothing queued", Tx_Data);
          end else begin
            if (Tx_Data !== expQ[0]) begin
              testsFailed++;
              $display("[TB] FAIL mon_order: Tx_Data=%h expected %h", Tx_Data, expQ[0]);
            end
            void'(expQ.pop_front());
            modelLevel--;
          end
          lastData = Tx_Data;
        end else begin
          testsRun++;
          if (Tx_Data !== lastData) begin
            testsFailed++;
            $display("[TB] FAIL mon_hold: Tx_Data=%h expected held %h", Tx_Data, lastData);
          end
        end
        testsRun++;
        if (Level !== (AW+1)'(modelLevel) || Full !== (modelLevel == DEPTH) ||
            Empty !== (modelLevel == 0)) begin
          testsFailed++;
          $display("[TB] FAIL mon_level: Level=%0d Full=%b Empty=%b expected Level=%0d",
                   Level, Full, Empty, modelLevel);
        end
        testsRun++;
        if (Overflow !== expOverflow) begin
          testsFailed++;
          $display("[TB] FAIL mon_overflow: Overflow=%b expected %b", Overflow, expOverflow);
        end
        resetPrev   = !Rst_n;
        pendWrite   = Rst_n && Wr_En && (modelLevel != DEPTH);
        pendByte    = Wr_Data;
        expOverflow = Rst_n && Wr_En && (modelLevel == DEPTH);
      end
    end
  end

  task automatic test_reset();
    Rst_n = 1'b0;
    Wr_En = 1'b1;
    Wr_Data = 8'h5A;
    tick();
    tick();
    testsRun++;
    if ({Full, Empty, Overflow, Busy, Tx_Start} !== 5'b01000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: Full/Empty/Ovf/Busy/Start=%b expected 01000",
               {Full, Empty, Overflow, Busy, Tx_Start});
    end
    testsRun++;
    if (Level !== '0 || Tx_Data !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: Level=%0d Tx_Data=%h expected 0 and 00", Level, Tx_Data);
    end
    Wr_En = 1'b0;
    Rst_n = 1'b1;
    monitorOn = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int n;
    frameLen = 80;
    eotHold  = 1'b0;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    Wr_En = 1'b1;
    Wr_Data = 8'hA5;
    tick();
    Wr_En = 1'b0;
    testsRun++;
    if (Tx_Start !== 1'b0 || Level !== 1) begin
      testsFailed++;
      $display("[TB] FAIL single_c1: Tx_Start=%b Level=%0d expected 0 and 1", Tx_Start, Level);
    end
    tick();
    testsRun++;
    if (Tx_Start !== 1'b1 || Tx_Data !== 8'hA5 || Level !== 0) begin
      testsFailed++;
      $display("[TB] FAIL single_c2: Tx_Start=%b Tx_Data=%h Level=%0d expected 1, a5, 0",
               Tx_Start, Tx_Data, Level);
    end
    tick();
    testsRun++;
    if (Tx_Start !== 1'b0 || Busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_c3: Tx_Start=%b Busy=%b expected 0 and 1", Tx_Start, Busy);
    end
    n = 0;
    while (!Tx_Eot && n < 200) begin
      tick();
      n++;
    end
    testsRun++;
    if (Tx_Eot !== 1'b1 || Busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_eot: Tx_Eot=%b Busy=%b expected 1 and 1", Tx_Eot, Busy);
    end
    tick();
    testsRun++;
    if (Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_busy: Busy=%b expected 0 after EOT", Busy);
    end
  endtask

  task automatic test_fill_overflow();
    int got;
    frameLen = 4;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    eotHold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      Wr_En = 1'b1;
      Wr_Data = 8'(i);
      tick();
      if (i == 15) begin
        testsRun++;
        if (Full !== 1'b1 || Level !== 16 || Overflow !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL fill_full: Full=%b Level=%0d Overflow=%b expected 1, 16, 0",
                   Full, Level, Overflow);
        end
      end
    end
    Wr_En = 1'b0;
    testsRun++;
    if (Overflow !== 1'b1 || Level !== 16) begin
      testsFailed++;
      $display("[TB] FAIL fill_ovf: Overflow=%b Level=%0d expected 1 and 16", Overflow, Level);
    end
    tick();
    testsRun++;
    if (Overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fill_ovf_pulse: Overflow=%b expected 0", Overflow);
    end
    eotHold = 1'b0;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      if (Tx_Start) begin
        testsRun++;
        if (Tx_Data !== 8'(got)) begin
          testsFailed++;
          $display("[TB] FAIL fill_drain: Tx_Data=%h expected %h", Tx_Data, 8'(got));
        end
        got++;
      end
      if (got >= 16 && !Busy) break;
      tick();
    end
    testsRun++;
    if (got !== 16 || Empty !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL fill_count: launches=%0d Empty=%b expected 16 and 1", got, Empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    int starts;
    int riseCycle;
    logic prevEot;
    vals = '{8'h11, 8'h22, 8'h33};
    frameLen = 80;
    eotHold  = 1'b0;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    starts = 0;
    riseCycle = -100;
    prevEot = Tx_Eot;
    for (int c = 0; c < 320; c++) begin
      if (Tx_Eot && !prevEot) riseCycle = c;
      prevEot = Tx_Eot;
      if (Tx_Start) begin
        starts++;
        if (starts > 1) begin
          testsRun++;
          if (c - riseCycle != 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_gap: start %0d came %0d cycles after EOT rise, expected 2",
                     starts, c - riseCycle);
          end
        end
      end
      if (starts > 0 && starts <= 3 && (Tx_Start || txCount > 0)) begin
        testsRun++;
        if (Tx_Data !== vals[starts-1]) begin
          testsFailed++;
          $display("[TB] FAIL b2b_data: Tx_Data=%h expected %h", Tx_Data, vals[starts-1]);
        end
      end
      Wr_En = (c < 3);
      Wr_Data = (c < 3) ? vals[c] : 8'h00;
      tick();
    end
    testsRun++;
    if (starts !== 3 || Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: starts=%0d Busy=%b expected 3 and 0", starts, Busy);
    end
  endtask

  task automatic test_simultaneous();
    frameLen = 0;
    eotHold  = 1'b0;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    Wr_En = 1'b1;
    Wr_Data = 8'($urandom);
    tick();
    Wr_Data = 8'($urandom);
    tick();
    Wr_En = 1'b0;
    testsRun++;
    if (Level !== 1 || Tx_Start !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL simul_first: Level=%0d Tx_Start=%b expected 1 and 1", Level, Tx_Start);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      testsRun++;
      if (Level !== 1) begin
        testsFailed++;
        $display("[TB] FAIL simul_wait: iter %0d Level=%0d expected 1", i, Level);
      end
      tick();
      Wr_En = 1'b1;
      Wr_Data = 8'($urandom);
      testsRun++;
      if (Level !== 1) begin
        testsFailed++;
        $display("[TB] FAIL simul_pop: iter %0d Level=%0d expected 1", i, Level);
      end
      tick();
      Wr_En = 1'b0;
      testsRun++;
      if (Level !== 1 || Tx_Start !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL simul_launch: iter %0d Level=%0d Tx_Start=%b expected 1 and 1",
                 i, Level, Tx_Start);
      end
    end
    for (int i = 0; i < 50 && Busy; i++) tick();
    testsRun++;
    if (Empty !== 1'b1 || Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL simul_drain: Empty=%b Busy=%b expected 1 and 0", Empty, Busy);
    end
  endtask

  task automatic test_full_write_pop();
    frameLen = 2;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    eotHold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      Wr_En = 1'b1;
      Wr_Data = 8'h40 + 8'(i);
      tick();
    end
    eotHold = 1'b0;
    Wr_Data = 8'hEE;
    tick();
    Wr_En = 1'b0;
    testsRun++;
    if (Overflow !== 1'b1 || Level !== 15 || Tx_Start !== 1'b1 || Tx_Data !== 8'h40) begin
      testsFailed++;
      $display("[TB] FAIL fullpop: Ovf=%b Level=%0d Start=%b Data=%h expected 1, 15, 1, 40",
               Overflow, Level, Tx_Start, Tx_Data);
    end
    for (int i = 0; i < 400 && Busy; i++) tick();
    testsRun++;
    if (Empty !== 1'b1 || Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fullpop_drain: Empty=%b Busy=%b expected 1 and 0", Empty, Busy);
    end
  endtask

  task automatic test_reset_mid();
    int starts;
    frameLen = 80;
    eotHold  = 1'b0;
    for (int i = 0; i < 300 && !(Busy == 1'b0 && Tx_Eot); i++) tick();
    for (int i = 0; i < 6; i++) begin
      Wr_En = 1'b1;
      Wr_Data = 8'hC0 + 8'(i);
      tick();
    end
    Wr_En = 1'b0;
    testsRun++;
    if (Level !== 5 || Busy !== 1'b1 || Tx_Data !== 8'hC0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_pre: Level=%0d Busy=%b Data=%h expected 5, 1, c0",
               Level, Busy, Tx_Data);
    end
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    testsRun++;
    if (Level !== 0 || Empty !== 1'b1 || Tx_Start !== 1'b0 || Tx_Data !== 8'h00 ||
        Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_post: Level=%0d Empty=%b Start=%b Data=%h Busy=%b expected 0,1,0,00,0",
               Level, Empty, Tx_Start, Tx_Data, Busy);
    end
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (Tx_Start) starts++;
    end
    testsRun++;
    if (starts !== 0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_quiet: starts=%0d expected 0", starts);
    end
    Wr_En = 1'b1;
    Wr_Data = 8'h3C;
    tick();
    Wr_En = 1'b0;
    tick();
    testsRun++;
    if (Tx_Start !== 1'b1 || Tx_Data !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_new: Start=%b Data=%h expected 1 and 3c", Tx_Start, Tx_Data);
    end
  endtask

  task automatic test_random();
    int wrPct;
    for (int phase = 0; phase < 3; phase++) begin
      frameLen = int'($urandom_range(0, 6));
      wrPct = (phase == 0) ? 60 : (phase == 1) ? 20 : 90;
      for (int c = 0; c < 500; c++) begin
        Wr_En = ($urandom_range(0, 99) < wrPct);
        Wr_Data = 8'($urandom);
        if ($urandom_range(0, 19) == 0) eotHold = !eotHold;
        tick();
      end
    end
    Wr_En = 1'b0;
    eotHold = 1'b0;
    for (int i = 0; i < 600 && Busy; i++) tick();
    testsRun++;
    if (Empty !== 1'b1 || Busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL random_drain: Empty=%b Busy=%b expected 1 and 0", Empty, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_back_to_back();
    test_simultaneous();
    test_full_write_pop();
    test_reset_mid();
    test_random();
    tick();
    monitorOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
